// File: rtl/axi4_lite_arbiter_if.sv
// AXI4-Lite channel bundle shared by the arbiter's requester ports and the
// downstream crossbar port. 32-bit address/data, 4-bit strobe, 2-bit response.
`timescale 1ns/1ps
interface axi4_lite_interface;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4_lite_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between the IFU and
// the LSU; one transaction is granted at a time and held until its response.
`timescale 1ns/1ps
module axi4_lite_arbiter (
  input  logic               clk,
  input  logic               rst,
  axi4_lite_interface.slave  ifu,
  axi4_lite_interface.slave  lsu,
  axi4_lite_interface.master out
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   last, last_nxt;
  logic   ar_done, ar_done_nxt;
  logic   aw_done, aw_done_nxt;
  logic   w_done, w_done_nxt;

  logic        ifu_req, lsu_req, winner, win_rd;
  logic        in_rd, in_wr, busy;
  logic [31:0] own_araddr, own_awaddr, own_wdata;
  logic [3:0]  own_wstrb;
  logic        own_arvalid, own_awvalid, own_wvalid, own_rready, own_bready;
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic        ar_rdy, aw_rdy, w_rdy, r_vld, b_vld;

  // Arbitration is only acted on in IDLE; the grant is registered, so no
  // requester valid reaches out.* combinationally before the next cycle.
  assign ifu_req = ifu.arvalid | ifu.awvalid;
  assign lsu_req = lsu.arvalid | lsu.awvalid;
  assign winner  = (ifu_req & lsu_req) ? ~last : lsu_req;
  assign win_rd  = winner ? lsu.arvalid : ifu.arvalid;

  assign in_rd = (state == RD);
  assign in_wr = (state == WR);
  assign busy  = in_rd | in_wr;

  assign own_araddr  = owner ? lsu.araddr  : ifu.araddr;
  assign own_arvalid = owner ? lsu.arvalid : ifu.arvalid;
  assign own_rready  = owner ? lsu.rready  : ifu.rready;
  assign own_awaddr  = owner ? lsu.awaddr  : ifu.awaddr;
  assign own_awvalid = owner ? lsu.awvalid : ifu.awvalid;
  assign own_wdata   = owner ? lsu.wdata   : ifu.wdata;
  assign own_wstrb   = owner ? lsu.wstrb   : ifu.wstrb;
  assign own_wvalid  = owner ? lsu.wvalid  : ifu.wvalid;
  assign own_bready  = owner ? lsu.bready  : ifu.bready;

  assign out.araddr  = busy ? own_araddr : 32'd0;
  assign out.arvalid = in_rd & own_arvalid & ~ar_done;
  assign out.rready  = in_rd & own_rready;
  assign out.awaddr  = busy ? own_awaddr : 32'd0;
  assign out.awvalid = in_wr & own_awvalid & ~aw_done;
  assign out.wdata   = busy ? own_wdata : 32'd0;
  assign out.wstrb   = busy ? own_wstrb : 4'd0;
  assign out.wvalid  = in_wr & own_wvalid & ~w_done;
  assign out.bready  = in_wr & own_bready;

  assign ar_hs = out.arvalid & out.arready;
  assign r_hs  = out.rvalid  & out.rready;
  assign aw_hs = out.awvalid & out.awready;
  assign w_hs  = out.wvalid  & out.wready;
  assign b_hs  = out.bvalid  & out.bready;

  // Once a channel has handshaken, its ready is hidden from the owner so a
  // follow-on request from the same requester waits for the next grant.
  assign ar_rdy = in_rd & out.arready & ~ar_done;
  assign r_vld  = in_rd & out.rvalid;
  assign aw_rdy = in_wr & out.awready & ~aw_done;
  assign w_rdy  = in_wr & out.wready & ~w_done;
  assign b_vld  = in_wr & out.bvalid;

  assign ifu.arready = ar_rdy & ~owner;
  assign ifu.rvalid  = r_vld  & ~owner;
  assign ifu.awready = aw_rdy & ~owner;
  assign ifu.wready  = w_rdy  & ~owner;
  assign ifu.bvalid  = b_vld  & ~owner;
  assign lsu.arready = ar_rdy & owner;
  assign lsu.rvalid  = r_vld  & owner;
  assign lsu.awready = aw_rdy & owner;
  assign lsu.wready  = w_rdy  & owner;
  assign lsu.bvalid  = b_vld  & owner;

  assign ifu.rdata = out.rdata;
  assign ifu.rresp = out.rresp;
  assign ifu.bresp = out.bresp;
  assign lsu.rdata = out.rdata;
  assign lsu.rresp = out.rresp;
  assign lsu.bresp = out.bresp;

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    last_nxt    = last;
    ar_done_nxt = ar_done;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    case (state)
      IDLE: begin
        if (ifu_req | lsu_req) begin
          owner_nxt = winner;
          last_nxt  = winner;
          state_nxt = win_rd ? RD : WR;
        end
      end
      RD: begin
        if (ar_hs) ar_done_nxt = 1'b1;
        if (r_hs) begin
          state_nxt   = IDLE;
          ar_done_nxt = 1'b0;
        end
      end
      WR: begin
        if (aw_hs) aw_done_nxt = 1'b1;
        if (w_hs)  w_done_nxt  = 1'b1;
        if (b_hs) begin
          state_nxt   = IDLE;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last resets to LSU so the IFU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      last    <= last_nxt;
      ar_done <= ar_done_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Scoreboard bench for axi4_lite_arbiter: directed requester traffic pushes
// expected grants and responses; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_axi4_lite_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_lite_interface ifu_if ();
  axi4_lite_interface lsu_if ();
  axi4_lite_interface out_if ();

  axi4_lite_arbiter dut (.clk(clk), .rst(rst), .ifu(ifu_if), .lsu(lsu_if), .out(out_if));

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {is_write, addr} in grant order; W as {wstrb, wdata}
  logic [32:0] exp_addr[$];
  logic [35:0] exp_w[$];
  logic [31:0] exp_ifu_r[$];
  logic [31:0] exp_lsu_r[$];
  logic [1:0]  exp_lsu_b[$];

  int  n_whs = 0, n_lsu_b = 0, ifu_r_cyc = 0, aw_rise_cyc = 0;
  bit  aw_prev = 1'b0, lsu_leak = 1'b0, leak_watch = 1'b0;
  int  aw_wait = 0, r_lat = 2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    n_total++;
    $display("FAIL %s: got 0x%0h, required no such event", name, act);
  endtask

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return {a[15:0], 16'hC0DE};
  endfunction

  function automatic bit queues_empty();
    return (exp_addr.size() == 0) && (exp_w.size() == 0) && (exp_ifu_r.size() == 0) &&
           (exp_lsu_r.size() == 0) && (exp_lsu_b.size() == 0);
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (out_if.arvalid && out_if.arready) begin
        if (exp_addr.size() == 0) fail("grant_ar", {31'd0, 1'b0, out_if.araddr});
        else chk("grant_ar", {1'b0, out_if.araddr}, exp_addr.pop_front());
      end
      if (out_if.awvalid && out_if.awready) begin
        if (exp_addr.size() == 0) fail("grant_aw", {31'd0, 1'b1, out_if.awaddr});
        else chk("grant_aw", {1'b1, out_if.awaddr}, exp_addr.pop_front());
      end
      if (out_if.wvalid && out_if.wready) begin
        n_whs++;
        if (exp_w.size() == 0) fail("w_beat", {out_if.wstrb, out_if.wdata});
        else chk("w_beat", {out_if.wstrb, out_if.wdata}, exp_w.pop_front());
      end
      if (ifu_if.rvalid && ifu_if.rready) begin
        ifu_r_cyc = cyc;
        if (exp_ifu_r.size() == 0) fail("ifu_rdata", ifu_if.rdata);
        else chk("ifu_rdata", ifu_if.rdata, exp_ifu_r.pop_front());
      end
      if (lsu_if.rvalid && lsu_if.rready) begin
        if (exp_lsu_r.size() == 0) fail("lsu_rdata", lsu_if.rdata);
        else chk("lsu_rdata", lsu_if.rdata, exp_lsu_r.pop_front());
      end
      if (lsu_if.bvalid && lsu_if.bready) begin
        n_lsu_b++;
        if (exp_lsu_b.size() == 0) fail("lsu_bresp", lsu_if.bresp);
        else chk("lsu_bresp", lsu_if.bresp, exp_lsu_b.pop_front());
      end
      if (ifu_if.bvalid) fail("ifu_bvalid", 1);
      if ((ifu_if.arready | ifu_if.awready | ifu_if.wready | ifu_if.rvalid | ifu_if.bvalid) &&
          (lsu_if.arready | lsu_if.awready | lsu_if.wready | lsu_if.rvalid | lsu_if.bvalid))
        fail("both_requesters_served", 1);
      if (leak_watch && (lsu_if.arready | lsu_if.awready | lsu_if.wready | lsu_if.rvalid | lsu_if.bvalid))
        lsu_leak = 1'b1;
      if (out_if.awvalid && !aw_prev) aw_rise_cyc = cyc;
      aw_prev = out_if.awvalid;
    end
  end

  // Downstream crossbar model: samples at negedge, drives just after posedge
  initial begin
    bit clr_r, clr_b, rd_pend, got_aw, got_w, b_pend;
    int rd_cnt, b_cnt, aw_cnt;
    logic [31:0] rd_addr, wr_addr;
    logic [1:0]  b_code;
    rd_pend = 0; got_aw = 0; got_w = 0; b_pend = 0; rd_cnt = 0; b_cnt = 0; aw_cnt = 0;
    rd_addr = '0; wr_addr = '0; b_code = '0;
    out_if.arready = 1'b1; out_if.awready = 1'b1; out_if.wready = 1'b1;
    out_if.rvalid = 1'b0; out_if.bvalid = 1'b0;
    out_if.rdata = '0; out_if.rresp = '0; out_if.bresp = '0;
    forever begin
      @(negedge clk);
      clr_r = 0; clr_b = 0;
      if (rst) begin
        rd_pend = 0; got_aw = 0; got_w = 0; b_pend = 0; aw_cnt = 0; clr_r = 1; clr_b = 1;
      end else begin
        clr_r = out_if.rvalid && out_if.rready;
        clr_b = out_if.bvalid && out_if.bready;
        if (out_if.arvalid && out_if.arready) begin
          rd_pend = 1; rd_cnt = r_lat; rd_addr = out_if.araddr;
        end
        if (out_if.awvalid && out_if.awready) begin
          got_aw = 1; wr_addr = out_if.awaddr; aw_cnt = 0;
        end else if (out_if.awvalid) aw_cnt++;
        if (out_if.wvalid && out_if.wready) got_w = 1;
        if (got_aw && got_w) begin
          got_aw = 0; got_w = 0; b_pend = 1; b_cnt = 1;
          b_code = (wr_addr[31:28] == 4'hF) ? 2'b10 : 2'b00;
        end
      end
      @(posedge clk); #1;
      if (clr_r) out_if.rvalid = 1'b0;
      if (clr_b) out_if.bvalid = 1'b0;
      if (rd_pend) begin
        rd_cnt--;
        if (rd_cnt <= 0) begin
          out_if.rvalid = 1'b1; out_if.rdata = rd_data(rd_addr); rd_pend = 0;
        end
      end
      if (b_pend) begin
        b_cnt--;
        if (b_cnt <= 0) begin
          out_if.bvalid = 1'b1; out_if.bresp = b_code; b_pend = 0;
        end
      end
      out_if.awready = (aw_wait == 0) || (aw_cnt >= aw_wait);
    end
  end

  // Requester tasks: called and return just after a rising edge
  task automatic ifu_read(input logic [31:0] a);
    bit ok = 0;
    ifu_if.araddr = a; ifu_if.arvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ifu_if.arready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    ifu_if.arvalid = 1'b0;
    if (!ok) fail("ifu_ar_timeout", a);
  endtask

  task automatic lsu_read(input logic [31:0] a);
    bit ok = 0;
    lsu_if.araddr = a; lsu_if.arvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (lsu_if.arready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    lsu_if.arvalid = 1'b0;
    if (!ok) fail("lsu_ar_timeout", a);
  endtask

  task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit a_ok = 0, w_ok = 0, a_hs, w_hs;
    lsu_if.awaddr = a; lsu_if.awvalid = 1'b1;
    lsu_if.wdata = d; lsu_if.wstrb = s; lsu_if.wvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a_hs = lsu_if.awvalid && lsu_if.awready;
      w_hs = lsu_if.wvalid && lsu_if.wready;
      @(posedge clk); #1;
      if (a_hs) begin lsu_if.awvalid = 1'b0; a_ok = 1; end
      if (w_hs) begin lsu_if.wvalid = 1'b0; w_ok = 1; end
      if (a_ok && w_ok) break;
    end
    if (!(a_ok && w_ok)) fail("lsu_write_timeout", a);
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (queues_empty()) begin done = 1; break; end
    end
    if (!done) fail(name, exp_addr.size() + exp_w.size() + exp_ifu_r.size() + exp_lsu_r.size() + exp_lsu_b.size());
    @(posedge clk); #1;
  endtask

  initial begin
    int w0, b0;
    ifu_if.arvalid = 0; ifu_if.araddr = '0; ifu_if.rready = 1;
    ifu_if.awvalid = 0; ifu_if.awaddr = '0; ifu_if.wvalid = 0; ifu_if.wdata = '0;
    ifu_if.wstrb = '0; ifu_if.bready = 1;
    lsu_if.arvalid = 0; lsu_if.araddr = '0; lsu_if.rready = 1;
    lsu_if.awvalid = 1; lsu_if.awaddr = 32'hA000_0000; lsu_if.wvalid = 1;
    lsu_if.wdata = 32'h55; lsu_if.wstrb = 4'hF; lsu_if.bready = 1;
    ifu_if.arvalid = 1; ifu_if.araddr = 32'h8000_0000;

    // Reset with requests pending: nothing may be granted or forwarded
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_quiet", {out_if.arvalid, out_if.awvalid, out_if.wvalid, out_if.rready, out_if.bready}, 0);
    chk("reset_req_quiet", {ifu_if.arready, ifu_if.awready, ifu_if.wready, ifu_if.rvalid, ifu_if.bvalid,
                            lsu_if.arready, lsu_if.awready, lsu_if.wready, lsu_if.rvalid, lsu_if.bvalid}, 0);
    @(posedge clk); #1;
    ifu_if.arvalid = 0; lsu_if.awvalid = 0; lsu_if.wvalid = 0;
    rst = 0;

    // Single IFU read
    exp_addr.push_back({1'b0, 32'h8000_0000});
    exp_ifu_r.push_back(32'h0000_0413);
    leak_watch = 1; lsu_leak = 0;
    fork
      ifu_read(32'h8000_0000);
      begin
        @(negedge clk); chk("ar_no_comb_path", out_if.arvalid, 0);
        @(negedge clk); chk("ar_one_cycle_latency", out_if.arvalid, 1);
      end
    join
    drain("t1_drain");
    @(negedge clk);
    chk("t1_back_to_idle", {out_if.arvalid, out_if.rready, out_if.awvalid, out_if.wvalid, out_if.bready}, 0);
    chk("t1_idle_addr_zero", out_if.araddr, 0);
    chk("t1_lsu_untouched", lsu_leak, 0);
    leak_watch = 0;
    @(posedge clk); #1;

    // Simultaneous request right after reset: IFU first, then LSU UART write
    rst = 1; @(posedge clk); #1; rst = 0;
    exp_addr.push_back({1'b0, 32'h8000_0004});
    exp_addr.push_back({1'b1, 32'hA000_03F8});
    exp_ifu_r.push_back(32'h0004_C0DE);
    exp_w.push_back({4'h1, 32'h0000_0041});
    exp_lsu_b.push_back(2'b00);
    w0 = n_whs;
    fork
      ifu_read(32'h8000_0004);
      lsu_write(32'hA000_03F8, 32'h0000_0041, 4'h1);
    join
    drain("t2_drain");
    chk("t2_one_uart_write", n_whs - w0, 1);
    // R handshake cycle, one IDLE bubble, then AW is on out
    chk("t2_aw_after_bubble", aw_rise_cyc - ifu_r_cyc, 2);

    // Round-robin: both keep requesting, grants must alternate
    exp_addr.push_back({1'b0, 32'h8000_0100});
    exp_addr.push_back({1'b1, 32'hA000_0200});
    exp_addr.push_back({1'b0, 32'h8000_0104});
    exp_addr.push_back({1'b1, 32'hA000_0204});
    exp_addr.push_back({1'b0, 32'h8000_0108});
    exp_addr.push_back({1'b1, 32'hF000_0208});
    exp_ifu_r.push_back(32'h0100_C0DE);
    exp_ifu_r.push_back(32'h0104_C0DE);
    exp_ifu_r.push_back(32'h0108_C0DE);
    exp_w.push_back({4'hF, 32'h1111_0001});
    exp_w.push_back({4'hC, 32'h2222_0002});
    exp_w.push_back({4'h3, 32'h3333_0003});
    exp_lsu_b.push_back(2'b00);
    exp_lsu_b.push_back(2'b00);
    exp_lsu_b.push_back(2'b10);
    fork
      begin
        ifu_read(32'h8000_0100);
        ifu_read(32'h8000_0104);
        ifu_read(32'h8000_0108);
      end
      begin
        lsu_write(32'hA000_0200, 32'h1111_0001, 4'hF);
        lsu_write(32'hA000_0204, 32'h2222_0002, 4'hC);
        lsu_write(32'hF000_0208, 32'h3333_0003, 4'h3);
      end
    join
    drain("t3_drain");

    // Write ordering: W accepted two cycles before AW
    aw_wait = 2;
    repeat (2) begin @(posedge clk); #1; end
    exp_addr.push_back({1'b1, 32'hA000_0100});
    exp_w.push_back({4'hF, 32'h1234_5678});
    exp_lsu_b.push_back(2'b00);
    b0 = n_lsu_b;
    fork
      lsu_write(32'hA000_0100, 32'h1234_5678, 4'hF);
      begin
        bit seen = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (out_if.awvalid) begin seen = 1; break; end
        end
        if (!seen) fail("t4_awvalid_timeout", 0);
        chk("t4_w_before_aw", {out_if.wvalid, out_if.wready, out_if.awready}, 3'b110);
        @(negedge clk);
        chk("t4_wvalid_dropped", out_if.wvalid, 0);
        chk("t4_awvalid_held", out_if.awvalid, 1);
        @(negedge clk);
        chk("t4_aw_handshake", {out_if.awvalid, out_if.awready}, 2'b11);
      end
    join
    drain("t4_drain");
    chk("t4_single_b", n_lsu_b - b0, 1);
    aw_wait = 0;
    repeat (2) begin @(posedge clk); #1; end

    // Reset while a read waits for its response
    r_lat = 8;
    exp_addr.push_back({1'b0, 32'h8000_0010});
    ifu_read(32'h8000_0010);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("t5_out_quiet", {out_if.arvalid, out_if.awvalid, out_if.wvalid, out_if.rready, out_if.bready}, 0);
    chk("t5_ifu_quiet", {ifu_if.arready, ifu_if.rvalid, ifu_if.awready, ifu_if.wready, ifu_if.bvalid}, 0);
    chk("t5_ar_consumed", exp_addr.size(), 0);
    r_lat = 2;
    @(posedge clk); #1;
    exp_addr.push_back({1'b0, 32'h8000_0020});
    exp_addr.push_back({1'b0, 32'hA000_0040});
    exp_ifu_r.push_back(32'h0020_C0DE);
    exp_lsu_r.push_back(32'h0040_C0DE);
    fork
      ifu_read(32'h8000_0020);
      lsu_read(32'hA000_0040);
    join
    drain("t5_drain");

    // Same requester read and write together: read first
    exp_addr.push_back({1'b0, 32'hA000_0080});
    exp_addr.push_back({1'b1, 32'hA000_0084});
    exp_lsu_r.push_back(32'h0080_C0DE);
    exp_w.push_back({4'h3, 32'hCAFE_F00D});
    exp_lsu_b.push_back(2'b00);
    fork
      lsu_read(32'hA000_0080);
      lsu_write(32'hA000_0084, 32'hCAFE_F00D, 4'h3);
    join
    drain("t6_drain");

    repeat (3) @(posedge clk);
    chk("all_expected_seen", queues_empty(), 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
